// File: rtl/fq_pkg.sv
// Shared definitions for the free-pointer queue: FSM encoding, count-width
// helper and the round-robin grant function used by the return arbiter.
package fq_pkg;

    typedef enum logic {
        FQ_INIT   = 1'b0,
        FQ_ACTIVE = 1'b1
    } fq_state_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Searches upward from the channel after 'last', wrapping at n, and grants
    // the first requester found. Supports up to eight channels.
    function automatic logic [7:0] rr_arb(input logic [7:0] req,
                                          input logic [2:0] last,
                                          input int         n);
        logic [7:0] gnt;
        logic       found;
        logic [2:0] pos;
        gnt   = '0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            pos = 3'((int'(last) + i) % n);
            if (i <= n && !found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/fq_fwft_fifo.sv
// First-word fall-through RAM FIFO holding free pointers. Read and write
// pointers carry an extra wrap bit so full and empty are unambiguous.
module fq_fwft_fifo #(
    parameter int PTR_W = 10,
    parameter int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [PTR_W-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt
);

    logic [PTR_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_wr;
    logic             do_rd;

    assign count = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A pop frees the slot the write lands in, so full plus pop still accepts.
    always_comb begin
        do_wr     = wr_en && (!full || rd_en);
        do_rd     = rd_en && !empty;
        wr_d      = wr_q + (AW+1)'(do_wr);
        rd_d      = rd_q + (AW+1)'(do_rd);
        count_nxt = wr_d - rd_d;
        rd_data   = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/free_ptr_queue.sv
// Free-pointer queue: self-loads pointers 0..DEPTH-1 after reset, then hands
// them out on the alloc side and takes them back from round-robin return ports.
module free_ptr_queue
    import fq_pkg::*;
#(
    parameter int PTR_W   = 10,
    parameter int DEPTH   = 512,
    parameter int NUM_RET = 2,
    parameter int LOW_WM  = 16,
    localparam int CNT_W  = cnt_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RET*PTR_W-1:0] ret_ptr,
    input  logic [NUM_RET-1:0]       ret_wr,
    output logic [NUM_RET-1:0]       ret_ack,
    input  logic                     alloc_rd,
    output logic [PTR_W-1:0]         alloc_ptr,
    output logic                     alloc_empty,
    output logic                     fq_act,
    output logic [CNT_W-1:0]         fq_count,
    output logic                     fq_low,
    output logic                     err_ovf,
    output logic                     err_unf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'((64'd1 << AW) - 64'd1);

    fq_state_e        state_q, state_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic [2:0]       last_q, last_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             low_q, low_d;

    logic [7:0]       req8;
    logic [7:0]       gnt8;
    logic [PTR_W-1:0] sel_ptr;
    logic             wr_en;
    logic [PTR_W-1:0] wr_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_count_nxt;

    fq_fwft_fifo #(
        .PTR_W (PTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (alloc_rd),
        .rd_data   (alloc_ptr),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count),
        .count_nxt (fifo_count_nxt)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        last_d     = last_q;
        req8       = '0;
        gnt8       = '0;
        sel_ptr    = '0;
        wr_en      = 1'b0;
        req8[NUM_RET-1:0] = ret_wr;

        case (state_q)
            FQ_INIT: begin
                wr_en   = 1'b1;
                sel_ptr = PTR_W'(init_cnt_q);
                if (init_cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = FQ_ACTIVE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            FQ_ACTIVE: begin
                gnt8  = rr_arb(req8, last_q, NUM_RET);
                wr_en = |gnt8;
                for (int i = 0; i < NUM_RET; i++) begin
                    if (gnt8[3'(i)]) begin
                        sel_ptr = ret_ptr[i*PTR_W +: PTR_W];
                        last_d  = 3'(i);
                    end
                end
            end
            default: state_d = FQ_INIT;
        endcase

        // Only the bits that address a buffer are kept.
        wr_data = sel_ptr & PTR_MASK;

        // A grant while full with no pop drops the pointer.
        ovf_d = ovf_q | (wr_en & fifo_full & ~alloc_rd);
        unf_d = unf_q | (alloc_rd & fifo_empty);
        low_d = (int'(fifo_count_nxt) < LOW_WM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FQ_INIT;
            init_cnt_q <= '0;
            last_q     <= 3'(NUM_RET - 1);
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            low_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            last_q     <= last_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            low_q      <= low_d;
        end
    end

    assign ret_ack     = gnt8[NUM_RET-1:0];
    assign alloc_empty = fifo_empty;
    assign fq_act      = (state_q == FQ_ACTIVE);
    assign fq_count    = fifo_count;
    assign fq_low      = low_q;
    assign err_ovf     = ovf_q;
    assign err_unf     = unf_q;

endmodule

// File: tb/tb_free_ptr_queue.sv
// Directed bench for free_ptr_queue: default 512-entry instance plus a small
// 64-entry, 4-channel instance for the initialisation sequence.
module tb_free_ptr_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] ret_ptr;
    logic [1:0]  ret_wr;
    logic [1:0]  ret_ack;
    logic        alloc_rd;
    logic [9:0]  alloc_ptr;
    logic        alloc_empty;
    logic        fq_act;
    logic [9:0]  fq_count;
    logic        fq_low;
    logic        err_ovf;
    logic        err_unf;

    logic        rst_s;
    logic [31:0] ret_ptr_s;
    logic [3:0]  ret_wr_s;
    logic [3:0]  ret_ack_s;
    logic        alloc_rd_s;
    logic [7:0]  alloc_ptr_s;
    logic        alloc_empty_s;
    logic        fq_act_s;
    logic [6:0]  fq_count_s;
    logic        fq_low_s;
    logic        err_ovf_s;
    logic        err_unf_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    free_ptr_queue u_dut (
        .clk         (clk),
        .rst         (rst),
        .ret_ptr     (ret_ptr),
        .ret_wr      (ret_wr),
        .ret_ack     (ret_ack),
        .alloc_rd    (alloc_rd),
        .alloc_ptr   (alloc_ptr),
        .alloc_empty (alloc_empty),
        .fq_act      (fq_act),
        .fq_count    (fq_count),
        .fq_low      (fq_low),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf)
    );

    free_ptr_queue #(.PTR_W(8), .DEPTH(64), .NUM_RET(4), .LOW_WM(16)) u_small (
        .clk         (clk),
        .rst         (rst_s),
        .ret_ptr     (ret_ptr_s),
        .ret_wr      (ret_wr_s),
        .ret_ack     (ret_ack_s),
        .alloc_rd    (alloc_rd_s),
        .alloc_ptr   (alloc_ptr_s),
        .alloc_empty (alloc_empty_s),
        .fq_act      (fq_act_s),
        .fq_count    (fq_count_s),
        .fq_low      (fq_low_s),
        .err_ovf     (err_ovf_s),
        .err_unf     (err_unf_s)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_init();
        rst = 1'b1; ret_wr = '0; alloc_rd = 1'b0;
        cyc();
        rst = 1'b0;
        repeat (512) cyc();
        total++; if (fq_act !== 1'b1 || fq_count !== 10'd512) begin bad++; $display("FAIL reinit act=%0b count=%0d want act=1 count=512", fq_act, fq_count); end
        total++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin bad++; $display("FAIL reinit_err ovf=%0b unf=%0b want 0 0", err_ovf, err_unf); end
    endtask

    task automatic test_reset();
        rst = 1'b1; ret_wr = 2'b11; ret_ptr = '0; alloc_rd = 1'b0;
        cyc(); cyc();
        total++; if (ret_ack !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b exp=00", ret_ack); end
        total++; if (alloc_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", alloc_empty); end
        total++; if (fq_act !== 1'b0) begin bad++; $display("FAIL rst_act got=%b exp=0", fq_act); end
        total++; if (fq_count !== 10'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", fq_count); end
        total++; if (fq_low !== 1'b1) begin bad++; $display("FAIL rst_low got=%b exp=1", fq_low); end
        total++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin bad++; $display("FAIL rst_err got=%b%b exp=00", err_ovf, err_unf); end
        total++; if (alloc_ptr !== 10'd0) begin bad++; $display("FAIL rst_ptr got=%0d exp=0", alloc_ptr); end
        rst = 1'b0;
        for (int k = 1; k <= 512; k++) begin
            cyc();
            if (k == 10) begin
                total++; if (fq_count !== 10'd10 || alloc_ptr !== 10'd0) begin bad++; $display("FAIL init10 count=%0d ptr=%0d want 10 0", fq_count, alloc_ptr); end
                total++; if (ret_ack !== 2'b00) begin bad++; $display("FAIL init_ack got=%b exp=00", ret_ack); end
            end
            if (k == 511) begin
                total++; if (fq_act !== 1'b0) begin bad++; $display("FAIL act_early got=%b exp=0", fq_act); end
                ret_wr = 2'b00;
            end
        end
        total++; if (fq_act !== 1'b1) begin bad++; $display("FAIL act_rise got=%b exp=1", fq_act); end
        total++; if (fq_count !== 10'd512) begin bad++; $display("FAIL full_count got=%0d exp=512", fq_count); end
        total++; if (alloc_empty !== 1'b0 || fq_low !== 1'b0) begin bad++; $display("FAIL full_flags empty=%b low=%b exp 0 0", alloc_empty, fq_low); end
    endtask

    task automatic test_pop_all();
        int errs = 0;
        int first_bad = -1;
        alloc_rd = 1'b1;
        for (int i = 0; i < 512; i++) begin
            if (alloc_ptr !== 10'(i)) begin errs++; if (first_bad < 0) first_bad = i; end
            cyc();
        end
        alloc_rd = 1'b0;
        total++; if (errs != 0) begin bad++; $display("FAIL pop_order wrong=%0d first_at=%0d exp 0 wrong", errs, first_bad); end
        total++; if (alloc_empty !== 1'b1 || fq_count !== 10'd0) begin bad++; $display("FAIL drained empty=%b count=%0d exp 1 0", alloc_empty, fq_count); end
    endtask

    task automatic test_underflow_low();
        alloc_rd = 1'b1;
        cyc();
        alloc_rd = 1'b0;
        total++; if (err_unf !== 1'b1 || fq_count !== 10'd0) begin bad++; $display("FAIL unf unf=%b count=%0d exp 1 0", err_unf, fq_count); end
        ret_wr = 2'b01; ret_ptr[9:0] = 10'd5; alloc_rd = 1'b1;
        #1;
        total++; if (ret_ack !== 2'b01) begin bad++; $display("FAIL unf_ack got=%b exp=01", ret_ack); end
        cyc();
        ret_wr = 2'b00; alloc_rd = 1'b0;
        total++; if (alloc_ptr !== 10'd5 || fq_count !== 10'd1) begin bad++; $display("FAIL wr_empty ptr=%0d count=%0d exp 5 1", alloc_ptr, fq_count); end
        ret_wr = 2'b10;
        for (int j = 0; j < 15; j++) begin
            ret_ptr[19:10] = 10'h200 | 10'(100 + j);
            cyc();
            if (j == 13) begin
                total++; if (fq_count !== 10'd15 || fq_low !== 1'b1) begin bad++; $display("FAIL low15 count=%0d low=%b exp 15 1", fq_count, fq_low); end
            end
        end
        ret_wr = 2'b00;
        total++; if (fq_count !== 10'd16 || fq_low !== 1'b0) begin bad++; $display("FAIL low16 count=%0d low=%b exp 16 0", fq_count, fq_low); end
        alloc_rd = 1'b1;
        cyc();
        alloc_rd = 1'b0;
        total++; if (fq_count !== 10'd15 || fq_low !== 1'b1) begin bad++; $display("FAIL low_back count=%0d low=%b exp 15 1", fq_count, fq_low); end
        total++; if (alloc_ptr !== 10'd100) begin bad++; $display("FAIL ptr_mask got=%0d exp=100", alloc_ptr); end
    endtask

    task automatic test_return_rr();
        for (int i = 0; i < 3; i++) begin
            total++; if (alloc_ptr !== 10'(i)) begin bad++; $display("FAIL pop3 got=%0d exp=%0d", alloc_ptr, i); end
            alloc_rd = 1'b1;
            cyc();
            alloc_rd = 1'b0;
        end
        total++; if (fq_count !== 10'd509) begin bad++; $display("FAIL cnt509 got=%0d exp=509", fq_count); end
        ret_ptr[9:0] = 10'd7; ret_ptr[19:10] = 10'd9; ret_wr = 2'b11;
        #1;
        total++; if (ret_ack !== 2'b01) begin bad++; $display("FAIL rr_first got=%b exp=01", ret_ack); end
        cyc();
        total++; if (fq_count !== 10'd510) begin bad++; $display("FAIL cnt510 got=%0d exp=510", fq_count); end
        ret_wr = 2'b10;
        #1;
        total++; if (ret_ack !== 2'b10) begin bad++; $display("FAIL rr_second got=%b exp=10", ret_ack); end
        cyc();
        ret_wr = 2'b00;
        total++; if (fq_count !== 10'd511) begin bad++; $display("FAIL cnt511 got=%0d exp=511", fq_count); end
        alloc_rd = 1'b1;
        repeat (509) cyc();
        alloc_rd = 1'b0;
        total++; if (alloc_ptr !== 10'd7) begin bad++; $display("FAIL tail7 got=%0d exp=7", alloc_ptr); end
        alloc_rd = 1'b1;
        cyc();
        total++; if (alloc_ptr !== 10'd9) begin bad++; $display("FAIL tail9 got=%0d exp=9", alloc_ptr); end
        cyc();
        alloc_rd = 1'b0;
        total++; if (alloc_empty !== 1'b1) begin bad++; $display("FAIL rr_empty got=%b exp=1", alloc_empty); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_ack;
        ret_ptr[9:0] = 10'd20; ret_ptr[19:10] = 10'd21; ret_wr = 2'b11;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_ack = (c % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (ret_ack !== exp_ack) begin bad++; $display("FAIL b2b_ack%0d got=%b exp=%b", c, ret_ack, exp_ack); end
            cyc();
        end
        ret_wr = 2'b00;
        total++; if (fq_count !== 10'd6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", fq_count); end
        alloc_rd = 1'b1;
        for (int c = 0; c < 6; c++) begin
            total++; if (alloc_ptr !== 10'(20 + c % 2)) begin bad++; $display("FAIL b2b_pop%0d got=%0d exp=%0d", c, alloc_ptr, 20 + c % 2); end
            cyc();
        end
        alloc_rd = 1'b0;
    endtask

    task automatic test_overflow();
        ret_ptr[9:0] = 10'd33; ret_wr = 2'b01;
        #1;
        total++; if (ret_ack !== 2'b01) begin bad++; $display("FAIL ovf_ack got=%b exp=01", ret_ack); end
        cyc();
        ret_wr = 2'b00;
        total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", err_ovf); end
        total++; if (fq_count !== 10'd512 || alloc_ptr !== 10'd0) begin bad++; $display("FAIL ovf_hold count=%0d ptr=%0d exp 512 0", fq_count, alloc_ptr); end
        ret_ptr[19:10] = 10'd44; ret_wr = 2'b10; alloc_rd = 1'b1;
        #1;
        total++; if (ret_ack !== 2'b10) begin bad++; $display("FAIL fullpop_ack got=%b exp=10", ret_ack); end
        cyc();
        ret_wr = 2'b00; alloc_rd = 1'b0;
        total++; if (fq_count !== 10'd512 || alloc_ptr !== 10'd1) begin bad++; $display("FAIL fullpop count=%0d ptr=%0d exp 512 1", fq_count, alloc_ptr); end
        total++; if (err_ovf !== 1'b1 || err_unf !== 1'b0) begin bad++; $display("FAIL fullpop_err ovf=%b unf=%b exp 1 0", err_ovf, err_unf); end
        alloc_rd = 1'b1;
        repeat (511) cyc();
        alloc_rd = 1'b0;
        total++; if (alloc_ptr !== 10'd44 || fq_count !== 10'd1) begin bad++; $display("FAIL fullpop_tail ptr=%0d count=%0d exp 44 1", alloc_ptr, fq_count); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (100) cyc();
        total++; if (fq_count !== 10'd100 || fq_act !== 1'b0) begin bad++; $display("FAIL mid_pre count=%0d act=%b exp 100 0", fq_count, fq_act); end
        rst = 1'b1;
        #1;
        total++; if (fq_count !== 10'd0 || alloc_empty !== 1'b1 || alloc_ptr !== 10'd0) begin bad++; $display("FAIL mid_rst count=%0d empty=%b ptr=%0d exp 0 1 0", fq_count, alloc_empty, alloc_ptr); end
        total++; if (fq_low !== 1'b1 || fq_act !== 1'b0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin bad++; $display("FAIL mid_flags low=%b act=%b ovf=%b unf=%b exp 1 0 0 0", fq_low, fq_act, err_ovf, err_unf); end
        cyc();
        rst = 1'b0;
        repeat (5) cyc();
        total++; if (fq_count !== 10'd5 || alloc_ptr !== 10'd0) begin bad++; $display("FAIL mid_restart count=%0d ptr=%0d exp 5 0", fq_count, alloc_ptr); end
    endtask

    task automatic test_small();
        int errs = 0;
        rst_s = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            cyc();
            if (k == 63) begin
                total++; if (fq_act_s !== 1'b0) begin bad++; $display("FAIL s_act_early got=%b exp=0", fq_act_s); end
            end
        end
        total++; if (fq_act_s !== 1'b1 || fq_count_s !== 7'd64) begin bad++; $display("FAIL s_active act=%b count=%0d exp 1 64", fq_act_s, fq_count_s); end
        alloc_rd_s = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (alloc_ptr_s !== 8'(i)) errs++;
            cyc();
        end
        alloc_rd_s = 1'b0;
        total++; if (errs != 0) begin bad++; $display("FAIL s_pop_order wrong=%0d exp=0", errs); end
        total++; if (alloc_empty_s !== 1'b1 || err_unf_s !== 1'b0) begin bad++; $display("FAIL s_drained empty=%b unf=%b exp 1 0", alloc_empty_s, err_unf_s); end
    endtask

    initial begin
        rst = 1'b1; ret_ptr = '0; ret_wr = '0; alloc_rd = 1'b0;
        rst_s = 1'b1; ret_ptr_s = '0; ret_wr_s = '0; alloc_rd_s = 1'b0;
        test_reset();
        test_pop_all();
        test_underflow_low();
        do_reset_init();
        test_return_rr();
        test_back_to_back();
        do_reset_init();
        test_overflow();
        test_mid_reset();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
